// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM command initiator.
package avalon_pkg;

  typedef enum logic [1:0] {
    OP_READ        = 2'b00,
    OP_WRITE       = 2'b01,
    OP_BURST_WRITE = 2'b10,
    OP_RSVD        = 2'b11
  } op_t;

  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [1:0] RESP_RSVD        = 2'b01;
  localparam logic [1:0] RESP_SLVERR      = 2'b10;
  localparam logic [1:0] RESP_DECODEERROR = 2'b11;

  localparam logic [10:0] MAX_ADDR_DEFAULT = 11'h62C;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_BW_FETCH,
    ST_BW_BEAT,
    ST_BW_RESP,
    ST_DONE
  } state_t;

  function automatic logic is_wait_state(input state_t s);
    return s inside {ST_RD_REQ, ST_RD_RESP, ST_WR_REQ, ST_WR_RESP, ST_BW_BEAT, ST_BW_RESP};
  endfunction

endpackage

// File: rtl/avalon_timeout_cnt.sv
// Slave-wait watchdog: down-counter reloaded on clear, flags when TIMEOUT enabled cycles have elapsed.
module avalon_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic rollover_o
);

  localparam logic [7:0] LOAD = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= LOAD;
    else        cnt_q <= cnt_d;
  end

  assign rollover_o = en_i && (cnt_q == 8'd0);

endmodule

// File: rtl/avalon_master.sv
// Avalon-MM initiator: one local READ / WRITE / BURST_WRITE command becomes one bus transaction.
// state | meaning: IDLE accept cmd | CHECK range check | RD_REQ/RD_RESP read addr/data phase |
// WR_REQ/WR_RESP write + response | BW_FETCH get beat data | BW_BEAT drive beat | BW_RESP burst resp | DONE pulse
module avalon_master
  import avalon_pkg::*;
#(
  parameter logic [10:0] MAX_ADDR = MAX_ADDR_DEFAULT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  op_t         cmd_op,
  input  logic [10:0] cmd_addr,
  input  logic [9:0]  cmd_len,
  input  logic [31:0] cmd_wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] rd_data,
  output logic [10:0] address,
  output logic        read,
  output logic        write,
  output logic        beginbursttransfer,
  output logic [9:0]  burstcount,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  input  logic        writeresponsevalid,
  input  logic [1:0]  response
);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [10:0] addr_q, addr_d;
  logic [9:0]  len_q, len_d, beat_q, beat_d;
  logic [31:0] cwdata_q, cwdata_d, rd_data_q, rd_data_d, writedata_q, writedata_d;
  logic [1:0]  status_q, status_d;
  logic [10:0] address_q;
  logic [9:0]  burstcount_q;
  logic        read_q, write_q, bbt_q, cmd_ready_q, wdata_ready_q, done_q;
  logic        tmo;
  logic        single_ok, burst_ok;
  logic [11:0] burst_end;

  avalon_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk        (clk),
    .n_rst      (n_rst),
    .clr_i      (state_d != state_q),
    .en_i       (is_wait_state(state_q)),
    .rollover_o (tmo)
  );

  assign burst_end = {1'b0, addr_q} + {2'b00, len_q};
  assign single_ok = (addr_q != 11'd0) && (addr_q < MAX_ADDR);
  assign burst_ok  = (len_q != 10'd0) && (burst_end < {1'b0, MAX_ADDR});

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cwdata_d    = cwdata_q;
    beat_d      = beat_q;
    status_d    = status_q;
    rd_data_d   = rd_data_q;
    writedata_d = writedata_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d     = cmd_op;
          addr_d   = cmd_addr;
          len_d    = cmd_len;
          cwdata_d = cmd_wdata;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        beat_d   = 10'd0;
        status_d = RESP_SLVERR;
        state_d  = ST_DONE;
        if ((op_q == OP_READ) && single_ok) begin
          state_d = ST_RD_REQ;
        end else if ((op_q == OP_WRITE) && single_ok) begin
          state_d     = ST_WR_REQ;
          writedata_d = cwdata_q;
        end else if ((op_q == OP_BURST_WRITE) && burst_ok) begin
          state_d = ST_BW_FETCH;
        end
      end
      ST_RD_REQ: begin
        if (!waitrequest) state_d = ST_RD_RESP;
        else if (tmo) begin
          status_d = RESP_DECODEERROR;
          state_d  = ST_DONE;
        end
      end
      ST_RD_RESP: begin
        if (readdatavalid) begin
          rd_data_d = readdata;
          status_d  = response;
          state_d   = ST_DONE;
        end else if (tmo) begin
          status_d = RESP_DECODEERROR;
          state_d  = ST_DONE;
        end
      end
      ST_WR_REQ: begin
        if (!waitrequest) state_d = ST_WR_RESP;
        else if (tmo) begin
          status_d = RESP_DECODEERROR;
          state_d  = ST_DONE;
        end
      end
      ST_BW_FETCH: begin
        if (wdata_valid && wdata_ready_q) begin
          writedata_d = wdata;
          state_d     = ST_BW_BEAT;
        end
      end
      ST_BW_BEAT: begin
        if (!waitrequest) begin
          beat_d  = beat_q + 10'd1;
          state_d = (beat_q == len_q - 10'd1) ? ST_BW_RESP : ST_BW_FETCH;
        end else if (tmo) begin
          status_d = RESP_DECODEERROR;
          state_d  = ST_DONE;
        end
      end
      ST_WR_RESP, ST_BW_RESP: begin
        // A response landing on the timeout cycle still counts.
        if (writeresponsevalid) begin
          status_d = response;
          state_d  = ST_DONE;
        end else if (tmo) begin
          status_d = RESP_DECODEERROR;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_READ;
      addr_q        <= '0;
      len_q         <= '0;
      cwdata_q      <= '0;
      beat_q        <= '0;
      status_q      <= '0;
      rd_data_q     <= '0;
      writedata_q   <= '0;
      address_q     <= '0;
      burstcount_q  <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      bbt_q         <= 1'b0;
      cmd_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      cwdata_q      <= cwdata_d;
      beat_q        <= beat_d;
      status_q      <= status_d;
      rd_data_q     <= rd_data_d;
      writedata_q   <= writedata_d;
      read_q        <= (state_d == ST_RD_REQ);
      write_q       <= (state_d == ST_WR_REQ) || (state_d == ST_BW_BEAT);
      bbt_q         <= (state_d == ST_BW_BEAT) && (beat_d == 10'd0);
      cmd_ready_q   <= (state_d == ST_IDLE);
      wdata_ready_q <= (state_d == ST_BW_FETCH);
      done_q        <= (state_d == ST_DONE);
      if (state_d == ST_BW_BEAT) begin
        address_q    <= addr_q;
        burstcount_q <= len_q;
      end else if ((state_d == ST_RD_REQ) || (state_d == ST_WR_REQ)) begin
        address_q    <= addr_q;
        burstcount_q <= 10'd1;
      end
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign wdata_ready        = wdata_ready_q;
  assign done               = done_q;
  assign status             = status_q;
  assign rd_data            = rd_data_q;
  assign address            = address_q;
  assign read               = read_q;
  assign write              = write_q;
  assign beginbursttransfer = bbt_q;
  assign burstcount         = burstcount_q;
  assign writedata          = writedata_q;

endmodule

// File: tb/tb_avalon_master.sv
// Directed bench for avalon_master; inputs change and outputs are sampled on the falling edge.
module tb_avalon_master;
  import avalon_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid, cmd_ready;
  op_t         cmd_op;
  logic [10:0] cmd_addr;
  logic [9:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        done;
  logic [1:0]  status;
  logic [31:0] rd_data;
  logic [10:0] address;
  logic        read, write, beginbursttransfer;
  logic [9:0]  burstcount;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid, writeresponsevalid;
  logic [1:0]  response;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_master #(.MAX_ADDR(11'h62C), .TIMEOUT(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .done(done), .status(status), .rd_data(rd_data),
    .address(address), .read(read), .write(write),
    .beginbursttransfer(beginbursttransfer), .burstcount(burstcount),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .writeresponsevalid(writeresponsevalid),
    .response(response)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command in IDLE; returns at the falling edge of the CHECK cycle.
  task automatic issue(input op_t op, input logic [10:0] a, input logic [9:0] n, input logic [31:0] d);
    chk("issue_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_len = n; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 0;
    chk("check_cmd_ready", cmd_ready, 0);
    chk("check_done", done, 0);
    chk("check_read", read, 0);
    chk("check_write", write, 0);
  endtask

  task automatic do_reject(input op_t op, input logic [10:0] a, input logic [9:0] n);
    issue(op, a, n, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rej_done", done, 1);
    chk("rej_status", status, 2'b10);
    chk("rej_read", read, 0);
    chk("rej_write", write, 0);
    @(negedge clk);
    chk("rej_done_low", done, 0);
    chk("rej_cmd_ready", cmd_ready, 1);
  endtask

  task automatic do_read(input logic [10:0] a, input int nwait, input logic [31:0] d, input logic [1:0] r);
    issue(OP_READ, a, 10'd0, 32'h0);
    waitrequest = (nwait > 0);
    for (int k = 0; k <= nwait; k++) begin
      @(negedge clk);
      chk("rd_read_high", read, 1);
      chk("rd_address", address, a);
      chk("rd_write_low", write, 0);
      if (k == nwait) waitrequest = 0;
    end
    @(negedge clk);
    chk("rd_read_dropped", read, 0);
    chk("rd_done_early", done, 0);
    readdatavalid = 1; readdata = d; response = r;
    @(negedge clk);
    readdatavalid = 0;
    chk("rd_done", done, 1);
    chk("rd_data", rd_data, d);
    chk("rd_status", status, r);
    @(negedge clk);
    chk("rd_done_low", done, 0);
    chk("rd_cmd_ready", cmd_ready, 1);
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [1:0] r);
    issue(OP_WRITE, a, 10'd0, d);
    waitrequest = 1;
    @(negedge clk);
    chk("wr_write_high", write, 1);
    chk("wr_writedata", writedata, d);
    chk("wr_address", address, a);
    chk("wr_burstcount", burstcount, 1);
    @(negedge clk);
    chk("wr_write_held", write, 1);
    chk("wr_read_low", read, 0);
    waitrequest = 0;
    @(negedge clk);
    chk("wr_write_dropped", write, 0);
    writeresponsevalid = 1; response = r;
    @(negedge clk);
    writeresponsevalid = 0;
    chk("wr_done", done, 1);
    chk("wr_status", status, r);
    @(negedge clk);
    chk("wr_done_low", done, 0);
  endtask

  // stall_beat: beat held one extra cycle by waitrequest; rst_beat: reset pulsed during that beat.
  task automatic do_burst(input logic [10:0] a, input logic [9:0] n, input int stall_beat, input int rst_beat);
    issue(OP_BURST_WRITE, a, n, 32'h0);
    waitrequest = 0;
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      chk("bw_wdata_ready", wdata_ready, 1);
      chk("bw_fetch_write", write, 0);
      wdata = 32'(i + 1);
      wdata_valid = 1;
      @(negedge clk);
      wdata_valid = 0;
      chk("bw_write", write, 1);
      chk("bw_begin", beginbursttransfer, (i == 0));
      chk("bw_burstcount", burstcount, n);
      chk("bw_address", address, a);
      chk("bw_writedata", writedata, 32'(i + 1));
      chk("bw_wdata_ready_low", wdata_ready, 0);
      if (i == rst_beat) begin
        n_rst = 0;
        #1;
        chk("rst_write", write, 0);
        chk("rst_begin", beginbursttransfer, 0);
        chk("rst_read", read, 0);
        chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_address", address, 0);
        chk("rst_burstcount", burstcount, 0);
        @(negedge clk);
        n_rst = 1;
        @(negedge clk);
        chk("rst_cmd_ready_after", cmd_ready, 1);
        chk("rst_done", done, 0);
        return;
      end
      if (i == stall_beat) begin
        waitrequest = 1;
        @(negedge clk);
        chk("bw_stall_write", write, 1);
        chk("bw_stall_data", writedata, 32'(i + 1));
        chk("bw_stall_begin", beginbursttransfer, (i == 0));
        waitrequest = 0;
      end
    end
    @(negedge clk);
    chk("bw_resp_write", write, 0);
    chk("bw_resp_done", done, 0);
    writeresponsevalid = 1; response = RESP_OKAY;
    @(negedge clk);
    writeresponsevalid = 0;
    chk("bw_done", done, 1);
    chk("bw_status", status, RESP_OKAY);
    @(negedge clk);
    chk("bw_done_low", done, 0);
    chk("bw_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    n_rst = 0; cmd_valid = 0; cmd_op = OP_READ; cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;
    wdata_valid = 0; wdata = '0; waitrequest = 0; readdata = '0; readdatavalid = 0;
    writeresponsevalid = 0; response = '0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_read", read, 0);
    chk("reset_write", write, 0);
    chk("reset_done", done, 0);
    chk("reset_address", address, 0);
    chk("reset_burstcount", burstcount, 0);
    chk("reset_writedata", writedata, 0);
    chk("reset_status", status, 0);
    chk("reset_rd_data", rd_data, 0);
    n_rst = 1;
    @(negedge clk);
    chk("post_reset_ready", cmd_ready, 1);

    do_read(11'h010, 2, 32'hDEADBEEF, RESP_OKAY);
    do_reject(OP_WRITE, 11'h000, 10'd0);
    do_reject(OP_WRITE, 11'h62C, 10'd0);
    do_reject(OP_READ, 11'h7FF, 10'd0);
    do_reject(OP_RSVD, 11'h010, 10'd0);
    do_write(11'h020, 32'hA5A5_0001, RESP_OKAY);
    do_burst(11'h100, 10'd4, 1, -1);
    do_reject(OP_BURST_WRITE, 11'h628, 10'd4);
    do_reject(OP_BURST_WRITE, 11'h100, 10'd0);
    do_burst(11'h628, 10'd3, -1, -1);

    // Silent slave: read must stay up for exactly 8 cycles, then abort.
    issue(OP_READ, 11'h040, 10'd0, 32'h0);
    waitrequest = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("tmo_read_high", read, 1);
      chk("tmo_done_early", done, 0);
    end
    @(negedge clk);
    chk("tmo_read_dropped", read, 0);
    chk("tmo_done", done, 1);
    chk("tmo_status", status, RESP_DECODEERROR);
    waitrequest = 0;
    @(negedge clk);
    chk("tmo_idle_ready", cmd_ready, 1);
    readdatavalid = 1; readdata = 32'hCAFE_F00D;
    @(negedge clk);
    readdatavalid = 0;
    chk("stray_done", done, 0);
    chk("stray_rd_data", rd_data, 32'hDEADBEEF);
    chk("stray_status", status, RESP_DECODEERROR);
    @(negedge clk);
    chk("stray_done2", done, 0);

    do_burst(11'h100, 10'd4, -1, 2);
    do_read(11'h055, 0, 32'h1234_5678, RESP_RSVD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
